// File: rtl/sha512_block_sequencer.sv
// Packs a byte stream big-endian into SHA-512 message blocks, appends the
// message padding and length, and sequences the hash core one block at a time.
module sha512_block_sequencer #(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        msg_data,
   input  logic              msg_valid,
   input  logic              msg_last,
   output logic              msg_ready,
   output logic [1023:0]     core_block,
   output logic              core_start,
   output logic              core_first,
   input  logic              core_done,
   output logic              hash_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  byte_count,
   output logic              len_ovf
);

   localparam int unsigned BLK_W    = 1024;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned LEN_W    = 128;
   localparam int unsigned IDX_W    = 8;
   localparam int unsigned LAST_IDX = 127;
   localparam int unsigned LEN_IDX  = 111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_PAD,
      S_LEN,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [BLK_W-1:0]      r_block;
   logic [IDX_W-1:0]      r_index;
   logic [CNT_W-1:0]      r_byte_count;
   logic                  r_len_ovf;
   logic                  r_first_pending;
   logic                  r_owe_80;
   logic                  r_final;
   logic                  r_pad_next;
   logic                  r_len_next;

   logic                  r_msg_ready;
   logic                  r_core_start;
   logic                  r_core_first;
   logic                  r_hash_valid;
   logic                  r_busy;

   logic                  w_msg_ready_nxt;
   logic                  w_core_start_nxt;
   logic                  w_core_first_nxt;
   logic                  w_hash_valid_nxt;
   logic                  w_busy_nxt;

   logic                  w_accept_st;
   logic                  w_xfer;
   logic                  w_shift;
   logic [BYTE_W-1:0]     w_byte;
   logic [LEN_W-1:0]      w_bit_len;
   logic                  w_at_last;
   logic                  w_at_len;
   logic                  w_enter_issue;

   assign w_accept_st   = (r_state == S_IDLE) || (r_state == S_FILL);
   assign w_xfer        = msg_valid & r_msg_ready & w_accept_st;
   assign w_shift       = w_xfer | (r_state == S_PAD);
   assign w_byte        = (r_state == S_PAD) ? (r_owe_80 ? 8'h80 : 8'h00) : msg_data;
   assign w_bit_len     = LEN_W'(r_byte_count) << 3;
   assign w_at_last     = (r_index == IDX_W'(LAST_IDX));
   assign w_at_len      = (r_index == IDX_W'(LEN_IDX));
   assign w_enter_issue = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_state_nxt = msg_last ? S_PAD : S_FILL;
            end
         end
         S_FILL: begin
            if (w_xfer) begin
               if (w_at_last) begin
                  w_state_nxt = S_ISSUE;
               end else if (msg_last) begin
                  w_state_nxt = S_PAD;
               end
            end
         end
         // Padding that started at index >= 112 runs to the block end instead
         S_PAD: begin
            if (w_at_last) begin
               w_state_nxt = S_ISSUE;
            end else if (w_at_len) begin
               w_state_nxt = S_LEN;
            end
         end
         S_LEN:   w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               if (r_final) begin
                  w_state_nxt = S_FINISH;
               end else if (r_pad_next || r_len_next) begin
                  w_state_nxt = S_PAD;
               end else begin
                  w_state_nxt = S_FILL;
               end
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output is a flop
   always_comb begin
      w_msg_ready_nxt  = 1'b0;
      w_core_start_nxt = 1'b0;
      w_core_first_nxt = 1'b0;
      w_hash_valid_nxt = 1'b0;
      w_busy_nxt       = 1'b1;
      case (w_state_nxt)
         S_IDLE: begin
            w_msg_ready_nxt = 1'b1;
            w_busy_nxt      = 1'b0;
         end
         S_FILL:   w_msg_ready_nxt = 1'b1;
         S_ISSUE: begin
            w_core_start_nxt = 1'b1;
            w_core_first_nxt = r_first_pending;
         end
         S_FINISH: w_hash_valid_nxt = 1'b1;
         default:  w_busy_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_msg_ready  <= 1'b0;
         r_core_start <= 1'b0;
         r_core_first <= 1'b0;
         r_hash_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_msg_ready  <= w_msg_ready_nxt;
         r_core_start <= w_core_start_nxt;
         r_core_first <= w_core_first_nxt;
         r_hash_valid <= w_hash_valid_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Block assembly, index and pad bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_block         <= '0;
         r_index         <= '0;
         r_owe_80        <= 1'b0;
         r_final         <= 1'b0;
         r_pad_next      <= 1'b0;
         r_len_next      <= 1'b0;
         r_first_pending <= 1'b0;
      end else begin
         if (w_shift) begin
            r_block <= {r_block[BLK_W-BYTE_W-1:0], w_byte};
            r_index <= r_index + IDX_W'(1);
         end else if (r_state == S_LEN) begin
            r_block <= {r_block[BLK_W-LEN_W-1:0], w_bit_len};
         end else if (r_state == S_ISSUE) begin
            r_index <= '0;
         end

         if (r_state == S_PAD) begin
            r_owe_80 <= 1'b0;
         end else if (w_xfer && (w_state_nxt == S_PAD)) begin
            r_owe_80 <= 1'b1;
         end else if ((r_state == S_WAIT) && (w_state_nxt == S_PAD)) begin
            r_owe_80 <= r_pad_next;
         end

         if (w_enter_issue) begin
            r_final    <= (r_state == S_LEN);
            r_pad_next <= (r_state == S_FILL) && msg_last;
            r_len_next <= (r_state == S_PAD);
         end

         if (w_xfer && (r_state == S_IDLE)) begin
            r_first_pending <= 1'b1;
         end else if (r_state == S_ISSUE) begin
            r_first_pending <= 1'b0;
         end
      end
   end

   // Message byte counter, saturating with a sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_count <= '0;
         r_len_ovf    <= 1'b0;
      end else if (w_xfer) begin
         if (r_state == S_IDLE) begin
            r_byte_count <= CNT_W'(1);
            r_len_ovf    <= 1'b0;
         end else if (&r_byte_count) begin
            r_len_ovf    <= 1'b1;
         end else begin
            r_byte_count <= r_byte_count + CNT_W'(1);
         end
      end
   end

   assign msg_ready  = r_msg_ready;
   assign core_block = r_block;
   assign core_start = r_core_start;
   assign core_first = r_core_first;
   assign hash_valid = r_hash_valid;
   assign busy       = r_busy;
   assign byte_count = r_byte_count;
   assign len_ovf    = r_len_ovf;

endmodule
